// File: rtl/mv_mode_sequencer.sv
// rtl/mv_mode_sequencer.sv - power-mode sequencer for the multi-voltage datapath
// Walks quiesce -> ramp -> settle -> release around every supply change; no-ack ramps end in sticky FAULT.
module mv_mode_sequencer #(
    parameter int ISO_CYC     = 2,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic perf_req,
    input  logic vreg_ack,
    output logic vsel,
    output logic iso_en,
    output logic clk_en,
    output logic high_perf_en,
    output logic busy,
    output logic err
);

    localparam int CW = $clog2(TIMEOUT_CYC + ISO_CYC + SETTLE_CYC + 1);
    localparam logic [CW-1:0] ISO_LAST    = CW'(ISO_CYC);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC);
    localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] BLANK_LAST  = CW'(2);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [2:0] {
        LOW_RUN, HIGH_RUN, QUIESCE, RAMP, SETTLE, RELEASE, FAULT
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            target_q;
    logic            vsel_q, iso_en_q, clk_en_q, high_perf_en_q, busy_q, err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= LOW_RUN;
            cnt_q          <= '0;
            target_q       <= 1'b0;
            vsel_q         <= 1'b0;
            iso_en_q       <= 1'b0;
            clk_en_q       <= 1'b1;
            high_perf_en_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            case (state_q)
                LOW_RUN, HIGH_RUN: begin
                    // A request differing from the current mode starts a transition.
                    if (perf_req != (state_q == HIGH_RUN)) begin
                        state_q        <= QUIESCE;
                        target_q       <= perf_req;
                        cnt_q          <= CNT_ONE;
                        iso_en_q       <= 1'b1;
                        clk_en_q       <= 1'b0;
                        busy_q         <= 1'b1;
                        high_perf_en_q <= 1'b0;
                    end
                end
                QUIESCE: begin
                    if (cnt_q == ISO_LAST) begin
                        state_q <= RAMP;
                        cnt_q   <= CNT_ONE;
                        vsel_q  <= target_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RAMP: begin
                    // The first two cycles ignore ack, which may still describe the old level.
                    if (cnt_q > BLANK_LAST && vreg_ack) begin
                        state_q <= SETTLE;
                        cnt_q   <= CNT_ONE;
                    end else if (cnt_q == TMO_LAST) begin
                        state_q        <= FAULT;
                        cnt_q          <= '0;
                        vsel_q         <= 1'b1;
                        high_perf_en_q <= 1'b0;
                        iso_en_q       <= 1'b0;
                        clk_en_q       <= 1'b1;
                        busy_q         <= 1'b0;
                        err_q          <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q        <= RELEASE;
                        cnt_q          <= '0;
                        iso_en_q       <= 1'b0;
                        high_perf_en_q <= target_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RELEASE: begin
                    state_q  <= target_q ? HIGH_RUN : LOW_RUN;
                    clk_en_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= FAULT;
                end
            endcase
        end
    end

    assign vsel         = vsel_q;
    assign iso_en       = iso_en_q;
    assign clk_en       = clk_en_q;
    assign high_perf_en = high_perf_en_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mv_mode_sequencer.sv
// tb/tb_mv_mode_sequencer.sv - directed checks of mv_mode_sequencer
// Output vector order: {vsel, iso_en, clk_en, high_perf_en, busy, err}.
module tb_mv_mode_sequencer;

    logic clk = 1'b0;
    logic reset, perf_req, vreg_ack;
    logic vsel, iso_en, clk_en, high_perf_en, busy, err;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [5:0] O_LOW  = 6'b001000;
    localparam logic [5:0] O_HIGH = 6'b101100;
    localparam logic [5:0] O_QLO  = 6'b010010;
    localparam logic [5:0] O_QHI  = 6'b110010;
    localparam logic [5:0] O_RELH = 6'b100110;
    localparam logic [5:0] O_RELL = 6'b000010;
    localparam logic [5:0] O_FLT  = 6'b101001;

    mv_mode_sequencer #(.ISO_CYC(2), .SETTLE_CYC(8), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .reset(reset), .perf_req(perf_req), .vreg_ack(vreg_ack),
        .vsel(vsel), .iso_en(iso_en), .clk_en(clk_en),
        .high_perf_en(high_perf_en), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    wire [5:0] outs = {vsel, iso_en, clk_en, high_perf_en, busy, err};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] exp);
        n_cmp++;
        assert (outs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
        end
        n_cmp++;
        assert (!(high_perf_en && !vsel))
        else begin
            n_err++;
            $error("FAIL %s_hpe_vsel observed=%b%b expected=not 10", tag, high_perf_en, vsel);
        end
    endtask

    initial begin
        reset = 1'b1; perf_req = 1'b0; vreg_ack = 1'b0;
        tick(); tick();
        check("reset", O_LOW);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("low_steady", O_LOW);
        end

        // Up transition, ack rising late in RAMP.
        perf_req = 1'b1;
        tick(); check("up_q1", O_QLO);
        tick(); check("up_q2", O_QLO);
        tick(); check("up_ramp1", O_QHI);
        tick(); check("up_ramp2", O_QHI);
        tick(); check("up_ramp3", O_QHI);
        vreg_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("up_settle", O_QHI);
        end
        tick(); check("up_release", O_RELH);
        tick(); check("up_high_run", O_HIGH);
        tick(); check("high_steady", O_HIGH);
        tick(); check("high_steady2", O_HIGH);

        // Down transition with ack held high: blanking sets the 14-cycle total.
        perf_req = 1'b0;
        tick(); check("dn_q_entry", O_QHI);
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1)       check("dn_q2", O_QHI);
            else if (i <= 12) check("dn_ramp_settle", O_QLO);
            else if (i == 13) check("dn_release", O_RELL);
            else              check("dn_low_run", O_LOW);
        end

        // Request pulsed during RAMP: target completes, then reversal on 2nd RUN cycle.
        perf_req = 1'b1;
        tick(); check("pulse_q", O_QLO);
        tick(); tick();
        check("pulse_ramp", O_QHI);
        tick();
        perf_req = 1'b0;
        for (int i = 4; i <= 12; i++) tick();
        check("pulse_settle_end", O_QHI);
        tick(); check("pulse_release", O_RELH);
        tick(); check("pulse_high_run", O_HIGH);
        tick(); check("pulse_down_q", O_QHI);
        for (int i = 0; i < 14; i++) tick();
        check("pulse_back_low", O_LOW);

        // Stuck-low ack leads to FAULT after 64 RAMP cycles.
        vreg_ack = 1'b0;
        perf_req = 1'b1;
        tick(); check("flt_q", O_QLO);
        for (int i = 1; i <= 65; i++) tick();
        check("flt_ramp_last", O_QHI);
        tick(); check("flt_entry", O_FLT);
        for (int i = 0; i < 4; i++) begin
            perf_req = ~perf_req;
            tick();
            check("flt_sticky", O_FLT);
        end
        reset = 1'b1; perf_req = 1'b0;
        tick(); check("flt_reset", O_LOW);
        reset = 1'b0;
        tick(); check("flt_after_reset", O_LOW);

        // Reset in the middle of SETTLE.
        perf_req = 1'b1; vreg_ack = 1'b1;
        tick();
        for (int i = 1; i <= 7; i++) tick();
        check("mid_settle", O_QHI);
        reset = 1'b1; perf_req = 1'b0;
        tick(); check("mid_settle_reset", O_LOW);
        reset = 1'b0;
        tick(); check("mid_settle_idle", O_LOW);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
